decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - Registered RV32I(+M) decode pipeline stage between fetch and execute; valid/ready on both sides, 2-entry skid buffer.
// - Emits a one-hot op vector (index constants in shared package), fields, immediate, operand-valid bits and illegal flag.
// - Supports pipeline flush; optional M extension via parameter.
// PARAMETERS
// - HAS_M      1   1: decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0: flag them illegal
// - PC_W       32  width of in_pc/out_pc
// - ZERO_RD    1   1: out_rd_valid forced 0 when rd==x0
// PORTS
// - clk            in   1        rising-edge clock
// - rst            in   1        synchronous, active-high reset
// - flush          in   1        discard all buffered instructions
// - in_valid       in   1        fetch offers in_instr/in_pc
// - in_ready       out  1        stage accepts this cycle
// - in_pc          in   PC_W     instruction address
// - in_instr       in   32       raw instruction
// - out_valid      out  1        decoded instruction available
// - out_ready      in   1        execute consumes this cycle
// - out_pc         out  PC_W     passthrough PC
// - out_op         out  NUM_OPS  one-hot op (all 0 if illegal)
// - out_imm        out  32       sign-extended I/S/B/J imm or U imm<<12; 0 for R-type
// - out_rs1/rs2/rd out  5 each   register indices, raw from instr
// - out_rs1_valid/out_rs2_valid/out_rd_valid out 1 each  operand use flags
// - out_illegal    out  1        unsupported/malformed instruction
// BEHAVIOUR
// - Reset: out_valid=0, in_ready=1, all out_* data=0, both buffer entries empty.
// - Latency: 1 cycle in->out when out side not stalled; throughput 1/cycle.
// - Transfer on in_valid&in_ready (input) / out_valid&out_ready (output). Outputs stable while out_valid&!out_ready.
// - in_ready is a register: 1 iff skid entry empty. Main entry drives outputs; skid entry fills only when main
//   held (out_valid&!out_ready) and an input transfer occurs; skid moves to main on next output transfer.
// - Simultaneous in+out transfer with main full, skid empty: main reloads from input, skid stays empty.
// - flush: next cycle both entries empty, out_valid=0, in_ready=1; an input offered in the flush cycle is dropped.
//   flush overrides rst-free operation only; rst overrides flush.
// - Decode is combinational from stored instr (decode on input, register result). Type by instr[6:2]:
//   00000/00100/11001 I, 01100 R, 01000 S, 11000 B, 11011 J, 01101/00101 U.
// - rs1_valid = !U & !J; rs2_valid = R|S|B; rd_valid = !S & !B (& rd!=0 if ZERO_RD).
// - Illegal: instr[1:0]!=2'b11; unknown opcode; undefined funct3/funct7 (e.g. SRLI funct7 not 0/0x20, shifts
//   with imm[25]=1); M-op with HAS_M=0; all-zero word. Illegal: out_op=0, out_illegal=1, valids=0, still passes.
// - Exactly one out_op bit set when out_valid & !out_illegal.
// STRUCTURE
// - Package riscv_dec_pkg: OP_* index localparams (LB..JALR, MUL..REMU, FENCE excluded), NUM_OPS, opcode
//   constants, decoded-bundle struct/width (op, imm, regs, valids, illegal).
// - Sub-module decode_core: pure combinational instr -> bundle, parameter HAS_M, ZERO_RD.
// - decode_stage: two bundle+pc registers (main, skid), handshake/flush control.
// TESTING
// - 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle OP_ADDI, imm=5, rd=1, rd_valid=1, rs2_valid=0.
// - 0x027302B3 (mul x5,x6,x7): HAS_M=1 -> OP_MUL; HAS_M=0 -> out_illegal=1, out_op=0.
// - 0xFE208EE3 (beq x1,x2,-4) -> OP_BEQ, imm=0xFFFFFFFC, rd_valid=0; 0x123452B7 (lui) -> imm=0x12345000, rs1_valid=0.
// - Backpressure: stream 4 instrs, out_ready=0 two cycles -> in_ready drops after 2 held, order preserved, no loss/dup.
// - flush with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed instrs never appear.
// - 0x00000000 and 0x00000013 with instr[1:0]=2'b01 -> out_illegal=1; rst mid-stream -> reset values next cycle.

Source files
------------

// File: rtl/riscv_dec_pkg.sv
// Shared decode definitions: op index constants, opcode values, decoded bundle.
package riscv_dec_pkg;

  // One-hot op vector layout: RV32I (without FENCE/SYSTEM) followed by M ops.
  localparam int NUM_OPS = 45;
  typedef logic [5:0] op_idx_t;

  localparam op_idx_t OP_LB     = 6'd0;
  localparam op_idx_t OP_LH     = 6'd1;
  localparam op_idx_t OP_LW     = 6'd2;
  localparam op_idx_t OP_LBU    = 6'd3;
  localparam op_idx_t OP_LHU    = 6'd4;
  localparam op_idx_t OP_ADDI   = 6'd5;
  localparam op_idx_t OP_SLTI   = 6'd6;
  localparam op_idx_t OP_SLTIU  = 6'd7;
  localparam op_idx_t OP_XORI   = 6'd8;
  localparam op_idx_t OP_ORI    = 6'd9;
  localparam op_idx_t OP_ANDI   = 6'd10;
  localparam op_idx_t OP_SLLI   = 6'd11;
  localparam op_idx_t OP_SRLI   = 6'd12;
  localparam op_idx_t OP_SRAI   = 6'd13;
  localparam op_idx_t OP_ADD    = 6'd14;
  localparam op_idx_t OP_SUB    = 6'd15;
  localparam op_idx_t OP_SLL    = 6'd16;
  localparam op_idx_t OP_SLT    = 6'd17;
  localparam op_idx_t OP_SLTU   = 6'd18;
  localparam op_idx_t OP_XOR    = 6'd19;
  localparam op_idx_t OP_SRL    = 6'd20;
  localparam op_idx_t OP_SRA    = 6'd21;
  localparam op_idx_t OP_OR     = 6'd22;
  localparam op_idx_t OP_AND    = 6'd23;
  localparam op_idx_t OP_SB     = 6'd24;
  localparam op_idx_t OP_SH     = 6'd25;
  localparam op_idx_t OP_SW     = 6'd26;
  localparam op_idx_t OP_BEQ    = 6'd27;
  localparam op_idx_t OP_BNE    = 6'd28;
  localparam op_idx_t OP_BLT    = 6'd29;
  localparam op_idx_t OP_BGE    = 6'd30;
  localparam op_idx_t OP_BLTU   = 6'd31;
  localparam op_idx_t OP_BGEU   = 6'd32;
  localparam op_idx_t OP_LUI    = 6'd33;
  localparam op_idx_t OP_AUIPC  = 6'd34;
  localparam op_idx_t OP_JAL    = 6'd35;
  localparam op_idx_t OP_JALR   = 6'd36;
  // M ops are laid out in funct3 order so OP_MUL + funct3 selects them.
  localparam op_idx_t OP_MUL    = 6'd37;
  localparam op_idx_t OP_MULH   = 6'd38;
  localparam op_idx_t OP_MULHSU = 6'd39;
  localparam op_idx_t OP_MULHU  = 6'd40;
  localparam op_idx_t OP_DIV    = 6'd41;
  localparam op_idx_t OP_DIVU   = 6'd42;
  localparam op_idx_t OP_REM    = 6'd43;
  localparam op_idx_t OP_REMU   = 6'd44;

  // instr[6:2] major opcode values.
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

  typedef struct packed {
    logic [NUM_OPS-1:0] op;
    logic [31:0]        imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               rs1_valid;
    logic               rs2_valid;
    logic               rd_valid;
    logic               illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  // Immediate assembly for each instruction format.
  function automatic logic [31:0] imm_of(input fmt_t fmt, input logic [31:0] i);
    case (fmt)
      FMT_I:   imm_of = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_J:   imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      FMT_U:   imm_of = {i[31:12], 12'h000};
      default: imm_of = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/decode_core.sv
// Pure combinational RV32I(+M) decoder: raw instruction word -> decoded bundle.
module decode_core
  import riscv_dec_pkg::*;
#(
  parameter bit HAS_M   = 1'b1,
  parameter bit ZERO_RD = 1'b1
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  op_idx_t    op_idx;
  logic       ill;
  fmt_t       fmt;

  assign opc = instr[6:2];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Classify the opcode, pick the op index and catch undefined encodings.
  always_comb begin
    op_idx = OP_ADDI;
    ill    = 1'b0;
    fmt    = FMT_R;
    case (opc)
      OPC_LOAD: begin
        fmt = FMT_I;
        case (f3)
          3'b000:  op_idx = OP_LB;
          3'b001:  op_idx = OP_LH;
          3'b010:  op_idx = OP_LW;
          3'b100:  op_idx = OP_LBU;
          3'b101:  op_idx = OP_LHU;
          default: ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        case (f3)
          3'b000: op_idx = OP_ADDI;
          3'b010: op_idx = OP_SLTI;
          3'b011: op_idx = OP_SLTIU;
          3'b100: op_idx = OP_XORI;
          3'b110: op_idx = OP_ORI;
          3'b111: op_idx = OP_ANDI;
          3'b001: begin
            op_idx = OP_SLLI;
            ill    = (f7 != 7'h00);
          end
          default: begin
            if (f7 == 7'h00)      op_idx = OP_SRLI;
            else if (f7 == 7'h20) op_idx = OP_SRAI;
            else                  ill = 1'b1;
          end
        endcase
      end
      OPC_JALR: begin
        fmt    = FMT_I;
        op_idx = OP_JALR;
        ill    = (f3 != 3'b000);
      end
      OPC_OP: begin
        fmt = FMT_R;
        case (f7)
          7'h00: begin
            case (f3)
              3'b000:  op_idx = OP_ADD;
              3'b001:  op_idx = OP_SLL;
              3'b010:  op_idx = OP_SLT;
              3'b011:  op_idx = OP_SLTU;
              3'b100:  op_idx = OP_XOR;
              3'b101:  op_idx = OP_SRL;
              3'b110:  op_idx = OP_OR;
              default: op_idx = OP_AND;
            endcase
          end
          7'h20: begin
            if (f3 == 3'b000)      op_idx = OP_SUB;
            else if (f3 == 3'b101) op_idx = OP_SRA;
            else                   ill = 1'b1;
          end
          7'h01: begin
            op_idx = OP_MUL + {3'b000, f3};
            ill    = !HAS_M;
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S;
        case (f3)
          3'b000:  op_idx = OP_SB;
          3'b001:  op_idx = OP_SH;
          3'b010:  op_idx = OP_SW;
          default: ill = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        case (f3)
          3'b000:  op_idx = OP_BEQ;
          3'b001:  op_idx = OP_BNE;
          3'b100:  op_idx = OP_BLT;
          3'b101:  op_idx = OP_BGE;
          3'b110:  op_idx = OP_BLTU;
          3'b111:  op_idx = OP_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        fmt    = FMT_J;
        op_idx = OP_JAL;
      end
      OPC_LUI: begin
        fmt    = FMT_U;
        op_idx = OP_LUI;
      end
      OPC_AUIPC: begin
        fmt    = FMT_U;
        op_idx = OP_AUIPC;
      end
      default: ill = 1'b1;
    endcase
    // Compressed/non-32-bit encodings (including the all-zero word) are rejected.
    if (instr[1:0] != 2'b11) ill = 1'b1;
  end

  // Assemble the bundle; an illegal word carries no op, no immediate and no operand uses.
  always_comb begin
    dec           = '0;
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.rd        = instr[11:7];
    dec.illegal   = ill;
    if (!ill) begin
      dec.op        = NUM_OPS'(1) << op_idx;
      dec.imm       = imm_of(fmt, instr);
      dec.rs1_valid = (fmt != FMT_U) && (fmt != FMT_J);
      dec.rs2_valid = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
      dec.rd_valid  = (fmt != FMT_S) && (fmt != FMT_B) &&
                      !(ZERO_RD && (instr[11:7] == 5'd0));
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode on input, main output register plus one skid entry.
module decode_stage
  import riscv_dec_pkg::*;
#(
  parameter bit HAS_M   = 1'b1,
  parameter int PC_W    = 32,
  parameter bit ZERO_RD = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [31:0]        in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [NUM_OPS-1:0] out_op,
  output logic [31:0]        out_imm,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic               out_rs1_valid,
  output logic               out_rs2_valid,
  output logic               out_rd_valid,
  output logic               out_illegal
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    dec_t            dec;
  } entry_t;

  dec_t   in_dec;
  entry_t in_entry;
  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  logic   main_valid_reg, main_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   in_ready_reg;
  logic   in_fire, out_fire;

  decode_core #(
    .HAS_M  (HAS_M),
    .ZERO_RD(ZERO_RD)
  ) u_core (
    .instr(in_instr),
    .dec  (in_dec)
  );

  assign in_entry = '{pc: in_pc, dec: in_dec};
  assign in_fire  = in_valid && in_ready_reg;
  assign out_fire = main_valid_reg && out_ready;

  // Entry movement: main refills from skid first, otherwise from input; skid catches input while main is held.
  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || out_fire) begin
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        main_valid_next = in_fire;
        if (in_fire) main_next = in_entry;
      end
    end else if (in_fire) begin
      skid_next       = in_entry;
      skid_valid_next = 1'b1;
    end
  end

  // State registers; in_ready is registered as "skid will be empty".
  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= !skid_valid_next;
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = main_valid_reg;
  assign out_pc        = main_reg.pc;
  assign out_op        = main_reg.dec.op;
  assign out_imm       = main_reg.dec.imm;
  assign out_rs1       = main_reg.dec.rs1;
  assign out_rs2       = main_reg.dec.rs2;
  assign out_rd        = main_reg.dec.rd;
  assign out_rs1_valid = main_reg.dec.rs1_valid;
  assign out_rs2_valid = main_reg.dec.rs2_valid;
  assign out_rd_valid  = main_reg.dec.rd_valid;
  assign out_illegal   = main_reg.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, queue of expected outputs, decoupled monitor.
module tb_decode_stage;
  import riscv_dec_pkg::*;

  logic               clk = 1'b0;
  logic               rst, flush, in_valid, out_ready;
  logic [31:0]        in_pc, in_instr;
  logic               in_ready, out_valid;
  logic [31:0]        out_pc, out_imm;
  logic [NUM_OPS-1:0] out_op;
  logic [4:0]         out_rs1, out_rs2, out_rd;
  logic               out_rs1_valid, out_rs2_valid, out_rd_valid, out_illegal;
  // Second instance without the M extension, same stimulus.
  logic               n_in_ready, n_out_valid;
  logic [31:0]        n_out_pc, n_out_imm;
  logic [NUM_OPS-1:0] n_out_op;
  logic [4:0]         n_out_rs1, n_out_rs2, n_out_rd;
  logic               n_out_rs1_valid, n_out_rs2_valid, n_out_rd_valid, n_out_illegal;

  int test_cnt = 0;
  int fail_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    op_idx_t     op;
    logic        ill;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1v, rs2v, rdv;
    logic        is_m;
  } exp_t;

  exp_t sb[$];

  decode_stage #(.HAS_M(1'b1), .PC_W(32), .ZERO_RD(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_imm(out_imm), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_rs1_valid(out_rs1_valid),
    .out_rs2_valid(out_rs2_valid), .out_rd_valid(out_rd_valid), .out_illegal(out_illegal));

  decode_stage #(.HAS_M(1'b0), .PC_W(32), .ZERO_RD(1'b1)) dut_nom (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .out_op(n_out_op), .out_imm(n_out_imm), .out_rs1(n_out_rs1),
    .out_rs2(n_out_rs2), .out_rd(n_out_rd), .out_rs1_valid(n_out_rs1_valid),
    .out_rs2_valid(n_out_rs2_valid), .out_rd_valid(n_out_rd_valid), .out_illegal(n_out_illegal));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input op_idx_t op,
                              input logic ill, input logic [31:0] imm, input logic r1v,
                              input logic r2v, input logic rdv, input logic is_m);
    exp_t e;
    e.pc = pc; e.op = op; e.ill = ill; e.imm = imm;
    e.rs1 = instr[19:15]; e.rs2 = instr[24:20]; e.rd = instr[11:7];
    e.rs1v = r1v; e.rs2v = r2v; e.rdv = rdv; e.is_m = is_m;
    return e;
  endfunction

  // Offer one instruction until accepted (bounded), then record its expected decode.
  task automatic send(input logic [31:0] instr, input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1; in_pc = e.pc; in_instr = instr;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk); done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (done) sb.push_back(e);
    else begin
      test_cnt++; fail_cnt++;
      $display("FAIL send_timeout: pc=0x%0h never accepted, expected in_ready=1", e.pc);
    end
  endtask

  // Monitor: pop and compare on every output transfer; also check outputs hold while stalled.
  logic        held_prev = 1'b0;
  logic [31:0] pc_prev;
  logic [NUM_OPS-1:0] op_prev;
  always @(negedge clk) begin
    logic [NUM_OPS-1:0] eop;
    exp_t e;
    if (held_prev && out_valid) begin
      chk("hold_pc", 64'(out_pc), 64'(pc_prev));
      chk("hold_op", 64'(out_op), 64'(op_prev));
    end
    held_prev = out_valid && !out_ready && !rst;
    pc_prev = out_pc; op_prev = out_op;
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        test_cnt++; fail_cnt++;
        $display("FAIL unexpected_output: pc=0x%0h appeared, expected no output", out_pc);
      end else begin
        e = sb.pop_front();
        eop = '0;
        if (!e.ill) eop[e.op] = 1'b1;
        $display("[TB] out pc=0x%0h op=0x%0h imm=0x%0h ill=%0b", out_pc, out_op, out_imm, out_illegal);
        chk("pc", 64'(out_pc), 64'(e.pc));
        chk("op", 64'(out_op), 64'(eop));
        chk("illegal", 64'(out_illegal), 64'(e.ill));
        chk("rs1_valid", 64'(out_rs1_valid), 64'(e.rs1v));
        chk("rs2_valid", 64'(out_rs2_valid), 64'(e.rs2v));
        chk("rd_valid", 64'(out_rd_valid), 64'(e.rdv));
        if (!e.ill) begin
          chk("imm", 64'(out_imm), 64'(e.imm));
          chk("rs1", 64'(out_rs1), 64'(e.rs1));
          chk("rs2", 64'(out_rs2), 64'(e.rs2));
          chk("rd", 64'(out_rd), 64'(e.rd));
        end
        chk("nom_valid", 64'(n_out_valid), 64'(1));
        chk("nom_pc", 64'(n_out_pc), 64'(e.pc));
        chk("nom_illegal", 64'(n_out_illegal), 64'(e.ill | e.is_m));
        chk("nom_op", 64'(n_out_op), e.is_m ? 64'(0) : 64'(eop));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic chk_idle(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  task automatic chk_reset_data(input string nm);
    chk({nm, "_out_pc"}, 64'(out_pc), 64'(0));
    chk({nm, "_out_op"}, 64'(out_op), 64'(0));
    chk({nm, "_out_imm"}, 64'(out_imm), 64'(0));
    chk({nm, "_out_rd"}, 64'(out_rd), 64'(0));
    chk({nm, "_out_illegal"}, 64'(out_illegal), 64'(0));
  endtask

  function automatic logic [31:0] addi_k(input int k);
    addi_k = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    chk_reset_data("reset");
    @(posedge clk); #1;

    // Directed decode vectors, no backpressure.
    out_ready = 1'b1;
    send(32'h00500093, mk(32'h100, 32'h00500093, OP_ADDI, 0, 32'd5, 1, 0, 1, 0));
    send(32'h027302B3, mk(32'h104, 32'h027302B3, OP_MUL, 0, 32'd0, 1, 1, 1, 1));
    send(32'hFE208EE3, mk(32'h108, 32'hFE208EE3, OP_BEQ, 0, 32'hFFFFFFFC, 1, 1, 0, 0));
    send(32'h123452B7, mk(32'h10C, 32'h123452B7, OP_LUI, 0, 32'h12345000, 0, 0, 1, 0));
    send(32'h0020A223, mk(32'h110, 32'h0020A223, OP_SW, 0, 32'd4, 1, 1, 0, 0));
    send(32'h40208033, mk(32'h114, 32'h40208033, OP_SUB, 0, 32'd0, 1, 1, 0, 0));
    send(32'h008000EF, mk(32'h118, 32'h008000EF, OP_JAL, 0, 32'd8, 0, 0, 1, 0));
    send(32'h00000000, mk(32'h11C, 32'h00000000, OP_LB, 1, 32'd0, 0, 0, 0, 0));
    send(32'h00000011, mk(32'h120, 32'h00000011, OP_LB, 1, 32'd0, 0, 0, 0, 0));
    send(32'h2010D093, mk(32'h124, 32'h2010D093, OP_LB, 1, 32'd0, 0, 0, 0, 0));
    repeat (3) @(posedge clk); #1;

    // Backpressure: two accepted while stalled fill main+skid, then in_ready drops.
    out_ready = 1'b0;
    send(addi_k(1), mk(32'h200, addi_k(1), OP_ADDI, 0, 32'd1, 1, 0, 1, 0));
    send(addi_k(2), mk(32'h204, addi_k(2), OP_ADDI, 0, 32'd2, 1, 0, 1, 0));
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    chk("bp_out_pc", 64'(out_pc), 64'(32'h200));
    @(posedge clk); #1;
    fork
      begin
        send(addi_k(3), mk(32'h208, addi_k(3), OP_ADDI, 0, 32'd3, 1, 0, 1, 0));
        send(addi_k(4), mk(32'h20C, addi_k(4), OP_ADDI, 0, 32'd4, 1, 0, 1, 0));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    chk("bp_drained", 64'(sb.size()), 64'(0));

    // Flush with main and skid full and a new input offered in the flush cycle.
    out_ready = 1'b0;
    send(addi_k(5), mk(32'h300, addi_k(5), OP_ADDI, 0, 32'd5, 1, 0, 1, 0));
    send(addi_k(6), mk(32'h304, addi_k(6), OP_ADDI, 0, 32'd6, 1, 0, 1, 0));
    in_valid = 1'b1; in_pc = 32'h308; in_instr = addi_k(7); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_idle("flush");
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(addi_k(8), mk(32'h30C, addi_k(8), OP_ADDI, 0, 32'd8, 1, 0, 1, 0));
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    send(addi_k(9), mk(32'h400, addi_k(9), OP_ADDI, 0, 32'd9, 1, 0, 1, 0));
    send(addi_k(10), mk(32'h404, addi_k(10), OP_ADDI, 0, 32'd10, 1, 0, 1, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk_idle("midrst");
    chk_reset_data("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(addi_k(11), mk(32'h500, addi_k(11), OP_ADDI, 0, 32'd11, 1, 0, 1, 0));
    repeat (4) @(posedge clk); #1;
    chk("final_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
